// File: rtl/right_shift_unit_if.sv
// Request/result handshake bundle for right_shift_unit.
// With RIGHT_ROTATE_EN defined, the bundle also carries the rot request bit.
interface right_shift_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start_valid;
  logic               start_ready;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
`ifdef RIGHT_ROTATE_EN
  logic               rot;
`endif
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   dout;

  // Requester / consumer side
  modport master (
    output start_valid, din, shamt, arith,
`ifdef RIGHT_ROTATE_EN
    output rot,
`endif
    output res_ready,
    input  start_ready, res_valid, dout
  );

  // Shifter side
  modport slave (
    input  start_valid, din, shamt, arith,
`ifdef RIGHT_ROTATE_EN
    input  rot,
`endif
    input  res_ready,
    output start_ready, res_valid, dout
  );
endinterface

// File: rtl/right_shift_unit.sv
// Multi-cycle right shifter (srl/sra), STEP bits per cycle, result held until taken.
// Optional feature macro: RIGHT_ROTATE_EN adds a rotate-right mode selected by rot.
// res_valid rises one cycle after the final shift, so a request accepted at edge N
// presents its result after edge N+1+ceil(shamt/STEP).
module right_shift_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  right_shift_unit_if.slave bus,
  output logic             busy
);
  localparam int unsigned KW = SHAMT_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               fill_q, fill_d;
  logic               start_ready_q, start_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
`ifdef RIGHT_ROTATE_EN
  logic               rot_q, rot_d;
`endif

  logic [KW-1:0]      k;
  logic [2*WIDTH-1:0] ext;

  // Bits shifted this cycle and the fill/rotate-extended operand
  always_comb begin
    k = (KW'(rem_q) < KW'(STEP)) ? KW'(rem_q) : KW'(STEP);
`ifdef RIGHT_ROTATE_EN
    ext = rot_q ? {dout_q, dout_q} : {{WIDTH{fill_q}}, dout_q};
`else
    ext = {{WIDTH{fill_q}}, dout_q};
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    rem_d       = rem_q;
    fill_d      = fill_q;
    res_valid_d = 1'b0;
`ifdef RIGHT_ROTATE_EN
    rot_d       = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          dout_d  = bus.din;
          rem_d   = bus.shamt;
          fill_d  = bus.arith & bus.din[WIDTH-1];
`ifdef RIGHT_ROTATE_EN
          rot_d   = bus.rot;
`endif
          state_d = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        dout_d = WIDTH'(ext >> k);
        rem_d  = rem_q - SHAMT_W'(k);
        if (KW'(rem_q) == k) state_d = DONE;
      end
      DONE: begin
        res_valid_d = 1'b1;
        if (res_valid_q && bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dout_q        <= '0;
      rem_q         <= '0;
      fill_q        <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef RIGHT_ROTATE_EN
      rot_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      dout_q        <= dout_d;
      rem_q         <= rem_d;
      fill_q        <= fill_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
`ifdef RIGHT_ROTATE_EN
      rot_q         <= rot_d;
`endif
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.dout        = dout_q;
  assign busy            = busy_q;
endmodule

// File: tb/tb_right_shift_unit.sv
// Directed bench for right_shift_unit: one STEP=1 and one STEP=4 instance.
module tb_right_shift_unit;
  logic clk;
  logic rst_n;
  logic busy1, busy4;
  int   total;
  int   passed;

  right_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus1 ();
  right_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus4 ();

  right_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1)
  );
  right_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] get_dout(input int sel);
    return (sel == 1) ? bus1.dout : bus4.dout;
  endfunction
  function automatic logic get_rv(input int sel);
    return (sel == 1) ? bus1.res_valid : bus4.res_valid;
  endfunction
  function automatic logic get_sr(input int sel);
    return (sel == 1) ? bus1.start_ready : bus4.start_ready;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy4;
  endfunction

  // Drive one request, wait for res_valid, check latency and result (result not consumed)
  task automatic do_req(input int sel, input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [31:0] exp_dout, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_start_ready"}, 32'(get_sr(sel)), 32'd1);
    if (sel == 1) begin
      bus1.din = d; bus1.shamt = s; bus1.arith = a; bus1.start_valid = 1'b1;
    end else begin
      bus4.din = d; bus4.shamt = s; bus4.arith = a; bus4.start_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus1.start_valid = 1'b0;
    bus4.start_valid = 1'b0;
    lat = 0;
    while (!get_rv(sel) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dout"}, get_dout(sel), exp_dout);
  endtask

  // Take the held result and check the unit returns to idle
  task automatic consume(input int sel, input string tag);
    @(negedge clk);
    if (sel == 1) bus1.res_ready = 1'b1; else bus4.res_ready = 1'b1;
    @(posedge clk); #1;
    bus1.res_ready = 1'b0;
    bus4.res_ready = 1'b0;
    check({tag, "_rv_clear"}, 32'(get_rv(sel)), 32'd0);
    check({tag, "_sr_back"}, 32'(get_sr(sel)), 32'd1);
    check({tag, "_busy_clear"}, 32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    bus1.start_valid = 1'b0; bus1.din = '0; bus1.shamt = '0; bus1.arith = 1'b0; bus1.res_ready = 1'b0;
    bus4.start_valid = 1'b0; bus4.din = '0; bus4.shamt = '0; bus4.arith = 1'b0; bus4.res_ready = 1'b0;
`ifdef RIGHT_ROTATE_EN
    bus1.rot = 1'b0;
    bus4.rot = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout1", bus1.dout, 32'h0);
    check("rst_rv1", 32'(bus1.res_valid), 32'd0);
    check("rst_sr1", 32'(bus1.start_ready), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_dout4", bus4.dout, 32'h0);
    check("rst_sr4", 32'(bus4.start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Logical shift by 4, STEP=1
    do_req(1, 32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000, 5, "t1");
    check("t1_busy_done", 32'(busy1), 32'd1);
    consume(1, "t1");

    // Arithmetic shift by 31 gives all sign bits
    do_req(1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, "t2");
    consume(1, "t2");

    // Arithmetic with positive operand fills zeros
    do_req(1, 32'h7000_0000, 5'd3, 1'b1, 32'h0E00_0000, 4, "t2b");
    consume(1, "t2b");

    // Zero shift, then a start pulse during DONE must be ignored
    do_req(1, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1, "t3");
    @(negedge clk);
    bus1.start_valid = 1'b1; bus1.din = 32'hDEAD_BEEF; bus1.shamt = 5'd0;
    @(negedge clk);
    check("t3_ignore_dout", bus1.dout, 32'h1234_5678);
    check("t3_ignore_sr", 32'(bus1.start_ready), 32'd0);
    check("t3_ignore_rv", 32'(bus1.res_valid), 32'd1);
    bus1.start_valid = 1'b0;
    consume(1, "t3");
    check("t3_dout_after", bus1.dout, 32'h1234_5678);

    // STEP=4, shamt=6 with backpressure
    do_req(4, 32'hF000_0000, 5'd6, 1'b0, 32'h03C0_0000, 3, "t4");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_bp_dout", bus4.dout, 32'h03C0_0000);
      check("t4_bp_rv", 32'(bus4.res_valid), 32'd1);
      check("t4_bp_sr", 32'(bus4.start_ready), 32'd0);
    end
    consume(4, "t4");

    // STEP=4 arithmetic shift by 31: ceil(31/4)=8
    do_req(4, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 9, "t4b");
    consume(4, "t4b");

    // STEP=4 shift smaller than STEP
    do_req(4, 32'h0000_0080, 5'd3, 1'b0, 32'h0000_0010, 2, "t4c");
    consume(4, "t4c");

    // Reset in the middle of a long shift
    @(negedge clk);
    bus1.din = 32'h1234_5678; bus1.shamt = 5'd20; bus1.arith = 1'b0; bus1.start_valid = 1'b1;
    @(posedge clk); #1;
    bus1.start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy_mid", 32'(busy1), 32'd1);
    check("t5_dout_mid", bus1.dout, 32'h0091_A2B3);
    check("t5_sr_mid", 32'(bus1.start_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", bus1.dout, 32'h0);
    check("t5_rst_rv", 32'(bus1.res_valid), 32'd0);
    check("t5_rst_sr", 32'(bus1.start_ready), 32'd1);
    check("t5_rst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 32'hA5A5_0000, 5'd8, 1'b1, 32'hFFA5_A500, 9, "t5_after");
    consume(1, "t5_after");

`ifdef RIGHT_ROTATE_EN
    // Rotate right versus plain shift
    bus1.rot = 1'b1;
    do_req(1, 32'h0000_0001, 5'd1, 1'b0, 32'h8000_0000, 2, "t6_rot");
    consume(1, "t6_rot");
    bus1.rot = 1'b0;
    do_req(1, 32'h0000_0001, 5'd1, 1'b0, 32'h0000_0000, 2, "t6_norot");
    consume(1, "t6_norot");
    // arith ignored under rotate; STEP=4 rotate by 6
    bus4.rot = 1'b1;
    do_req(4, 32'h8000_000F, 5'd6, 1'b1, 32'h3E00_0000, 3, "t6_rot4");
    consume(4, "t6_rot4");
    bus4.rot = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
